// File: rtl/ps2_tx.sv
// rtl/ps2_tx.sv - host-to-device PS/2 command transmitter with register interface
//
// Sends one byte to a PS/2 device: inhibit (clock low), request (data low),
// eight data bits LSB first, odd parity, stop (line released), then samples
// the device acknowledge and waits for both lines to return high.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   a, d, we          register select, write data, single-cycle write strobe
//   spo               combinational read data for register a
//   irq               level interrupt (done & irq_en)
//   busy              high while a transfer is in progress
//   ps2_clk_i         PS/2 clock pin level (asynchronous)
//   ps2_data_i        PS/2 data pin level (asynchronous)
//   ps2_clk_oe        1 pulls the clock pin low
//   ps2_data_oe       1 pulls the data pin low
//
// Registers:
//   a=0 write: start a transfer of d[7:0] (ignored unless idle)
//   a=0 read : {28'b0, err, ack_ok, done, busy}
//   a=1 write: d[0]=1 clears done/err, d[1] loads irq_en
//   a=1 read : {30'b0, irq_en, 1'b0}
module ps2_tx #(
   parameter int INHIBIT_CYCLES = 6250,
   parameter int TIMEOUT_CYCLES = 1250000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        a,
   input  logic [31:0] d,
   input  logic        we,
   output logic [31:0] spo,
   output logic        irq,
   output logic        busy,
   input  logic        ps2_clk_i,
   input  logic        ps2_data_i,
   output logic        ps2_clk_oe,
   output logic        ps2_data_oe
);

   localparam int IW = $clog2(INHIBIT_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_INHIBIT,
      S_REQ,
      S_DATA,
      S_ACK,
      S_WAIT_IDLE
   } state_t;

   state_t        state;
   logic [7:0]    shreg;
   logic          parity;
   logic [3:0]    bit_cnt;
   logic [IW-1:0] inh_cnt;
   logic [TW-1:0] tmo_cnt;
   logic          done;
   logic          ack_ok;
   logic          err;
   logic          irq_en;

   logic clk_s1, clk_s2, clk_h;
   logic data_s1, data_s2, data_h;
   logic fall_clk;

   logic unused_bits;
   assign unused_bits = ^{d[31:8], data_h};

   assign fall_clk = clk_h & ~clk_s2;
   assign busy     = (state != S_IDLE);
   assign irq      = done & irq_en;
   assign spo      = a ? {30'b0, irq_en, 1'b0} : {28'b0, err, ack_ok, done, busy};

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         shreg       <= 8'h00;
         parity      <= 1'b0;
         bit_cnt     <= 4'd0;
         inh_cnt     <= '0;
         tmo_cnt     <= '0;
         done        <= 1'b0;
         ack_ok      <= 1'b0;
         err         <= 1'b0;
         irq_en      <= 1'b0;
         ps2_clk_oe  <= 1'b0;
         ps2_data_oe <= 1'b0;
         // Idle PS/2 lines are high; presetting avoids a false edge after reset.
         clk_s1      <= 1'b1;
         clk_s2      <= 1'b1;
         clk_h       <= 1'b1;
         data_s1     <= 1'b1;
         data_s2     <= 1'b1;
         data_h      <= 1'b1;
      end else begin
         clk_s1  <= ps2_clk_i;
         clk_s2  <= clk_s1;
         clk_h   <= clk_s2;
         data_s1 <= ps2_data_i;
         data_s2 <= data_s1;
         data_h  <= data_s2;

         // Software clear first so that any hardware set below overrides it.
         if (we && a) begin
            if (d[0]) begin
               done <= 1'b0;
               err  <= 1'b0;
            end
            irq_en <= d[1];
         end

         case (state)
            S_IDLE: begin
               ps2_clk_oe  <= 1'b0;
               ps2_data_oe <= 1'b0;
               if (we && !a) begin
                  shreg      <= d[7:0];
                  parity     <= ~^d[7:0];
                  ack_ok     <= 1'b0;
                  err        <= 1'b0;
                  done       <= 1'b0;
                  inh_cnt    <= '0;
                  ps2_clk_oe <= 1'b1;
                  state      <= S_INHIBIT;
               end
            end

            S_INHIBIT: begin
               if (inh_cnt == INH_LAST) begin
                  ps2_clk_oe  <= 1'b0;
                  ps2_data_oe <= 1'b1;
                  tmo_cnt     <= '0;
                  bit_cnt     <= 4'd0;
                  state       <= S_REQ;
               end else begin
                  inh_cnt <= inh_cnt + 1'b1;
               end
            end

            S_REQ, S_DATA, S_ACK, S_WAIT_IDLE: begin
               tmo_cnt <= tmo_cnt + 1'b1;
               if (tmo_cnt == TMO_LAST) begin
                  ps2_clk_oe  <= 1'b0;
                  ps2_data_oe <= 1'b0;
                  err         <= 1'b1;
                  done        <= 1'b1;
                  ack_ok      <= 1'b0;
                  state       <= S_IDLE;
               end else begin
                  case (state)
                     // The device's first falling edge (seen in REQ) is already
                     // the bit-0 edge, so REQ and DATA share the per-edge action.
                     S_REQ, S_DATA: begin
                        if (fall_clk) begin
                           if (bit_cnt < 4'd8)
                              ps2_data_oe <= ~shreg[bit_cnt[2:0]];
                           else if (bit_cnt == 4'd8)
                              ps2_data_oe <= ~parity;
                           else
                              ps2_data_oe <= 1'b0;
                           bit_cnt <= bit_cnt + 1'b1;
                           state   <= (bit_cnt == 4'd9) ? S_ACK : S_DATA;
                        end
                     end
                     S_ACK: begin
                        if (fall_clk) begin
                           if (!data_s2)
                              ack_ok <= 1'b1;
                           state <= S_WAIT_IDLE;
                        end
                     end
                     S_WAIT_IDLE: begin
                        if (clk_s2 && data_s2) begin
                           done  <= 1'b1;
                           state <= S_IDLE;
                        end
                     end
                     default: ;
                  endcase
               end
            end

            default: begin
               ps2_clk_oe  <= 1'b0;
               ps2_data_oe <= 1'b0;
               state       <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ps2_tx.sv
// tb/tb_ps2_tx.sv - directed bench for ps2_tx with a simple PS/2 device model
module tb_ps2_tx;

   localparam int INH = 20;
   localparam int TMO = 200;

   logic        clk = 1'b0;
   logic        rst;
   logic        a;
   logic [31:0] d;
   logic        we;
   logic [31:0] spo;
   logic        irq;
   logic        busy;
   logic        ps2_clk_i;
   logic        ps2_data_i;
   logic        ps2_clk_oe;
   logic        ps2_data_oe;
   logic        dev_clk_low;
   logic        dev_data_low;

   int vectors = 0;
   int miscompares = 0;

   assign ps2_clk_i  = ~(ps2_clk_oe | dev_clk_low);
   assign ps2_data_i = ~(ps2_data_oe | dev_data_low);

   ps2_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst(rst), .a(a), .d(d), .we(we), .spo(spo), .irq(irq), .busy(busy),
      .ps2_clk_i(ps2_clk_i), .ps2_data_i(ps2_data_i),
      .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
   );

   always #5 clk = ~clk;

   task automatic reg_write(input logic sel, input logic [31:0] val);
      @(negedge clk);
      a = sel; d = val; we = 1'b1;
      @(negedge clk);
      we = 1'b0;
   endtask

   task automatic read_status(output logic [31:0] v);
      a = 1'b0;
      #1;
      v = spo;
   endtask

   // Counts cycles the clock line is held low; reports data oe at release.
   task automatic measure_inhibit(output int n, output logic dat);
      n = 0;
      while (ps2_clk_oe && n < 1000) begin
         n++;
         @(negedge clk);
      end
      dat = ps2_data_oe;
   endtask

   // Device: waits for request, clocks npulses, samples data on each rise;
   // pulse 11 is the acknowledge clock.
   task automatic dev_frame(input int npulses, input bit do_ack,
                            output logic [9:0] bits, output bit ok);
      int n;
      bits = '0;
      ok = 1'b1;
      n = 0;
      while (!(ps2_data_i == 1'b0 && ps2_clk_i == 1'b1) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         ok = 1'b0;
         return;
      end
      repeat (5) @(negedge clk);
      for (int i = 0; i < npulses; i++) begin
         if (i == 10 && do_ack) begin
            dev_data_low = 1'b1;
            repeat (3) @(negedge clk);
         end
         dev_clk_low = 1'b1;
         repeat (6) @(negedge clk);
         dev_clk_low = 1'b0;
         if (i < 10) bits[i] = ps2_data_i;
         repeat (6) @(negedge clk);
         dev_data_low = 1'b0;
      end
   endtask

   task automatic wait_idle(output bit ok);
      int n;
      n = 0;
      while (busy && n < 400) begin
         @(negedge clk);
         n++;
      end
      ok = !busy;
   endtask

   task automatic test_reset;
      logic [31:0] v;
      rst = 1'b1; a = 1'b0; d = '0; we = 1'b0; dev_clk_low = 1'b0; dev_data_low = 1'b0;
      repeat (3) @(negedge clk);
      vectors++;
      if ({ps2_clk_oe, ps2_data_oe, busy, irq} !== 4'b0000) begin
         miscompares++;
         $display("FAIL reset_outputs: got %b expected 0000", {ps2_clk_oe, ps2_data_oe, busy, irq});
      end
      read_status(v);
      vectors++;
      if (v !== 32'h0) begin miscompares++; $display("FAIL reset_status: got %h expected 0", v); end
      a = 1'b1; #1;
      vectors++;
      if (spo !== 32'h0) begin miscompares++; $display("FAIL reset_ctrl: got %h expected 0", spo); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_send_ack;
      int n; logic dat; logic [9:0] bits; bit ok; logic [31:0] v;
      reg_write(1'b0, 32'h0000_00ED);
      vectors++;
      if ({busy, ps2_clk_oe, ps2_data_oe} !== 3'b110) begin
         miscompares++;
         $display("FAIL ed_start: got %b expected 110", {busy, ps2_clk_oe, ps2_data_oe});
      end
      measure_inhibit(n, dat);
      vectors++;
      if (n !== INH) begin miscompares++; $display("FAIL ed_inhibit_len: got %0d expected %0d", n, INH); end
      vectors++;
      if (dat !== 1'b1) begin miscompares++; $display("FAIL ed_start_bit: got %b expected 1", dat); end
      dev_frame(11, 1'b1, bits, ok);
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL ed_request_seen: got 0 expected 1"); end
      vectors++;
      if (bits !== 10'b11_1110_1101) begin
         miscompares++;
         $display("FAIL ed_bits: got %b expected 1111101101", bits);
      end
      wait_idle(ok);
      read_status(v);
      vectors++;
      if (!ok || v !== 32'h6) begin miscompares++; $display("FAIL ed_status: got %h expected 6", v); end
   endtask

   task automatic test_send_noack;
      int n; logic dat; logic [9:0] bits; bit ok; logic [31:0] v;
      reg_write(1'b0, 32'h0000_0001);
      measure_inhibit(n, dat);
      dev_frame(11, 1'b0, bits, ok);
      vectors++;
      if (bits !== 10'b10_0000_0001) begin
         miscompares++;
         $display("FAIL noack_bits: got %b expected 1000000001", bits);
      end
      wait_idle(ok);
      read_status(v);
      vectors++;
      if (!ok || v !== 32'h2) begin miscompares++; $display("FAIL noack_status: got %h expected 2", v); end
   endtask

   task automatic test_busy_write;
      int n; logic dat; logic [9:0] bits; bit ok; logic [31:0] v;
      reg_write(1'b0, 32'h0000_00F4);
      repeat (5) @(negedge clk);
      reg_write(1'b0, 32'h0000_0055);
      measure_inhibit(n, dat);
      fork
         dev_frame(11, 1'b1, bits, ok);
         begin
            repeat (40) @(negedge clk);
            reg_write(1'b0, 32'h0000_0055);
         end
      join
      vectors++;
      if (bits !== 10'b10_1111_0100) begin
         miscompares++;
         $display("FAIL busywr_bits: got %b expected 1011110100", bits);
      end
      wait_idle(ok);
      read_status(v);
      vectors++;
      if (!ok || v !== 32'h6) begin miscompares++; $display("FAIL busywr_status: got %h expected 6", v); end
      repeat (30) @(negedge clk);
      vectors++;
      if ({busy, ps2_clk_oe} !== 2'b00) begin
         miscompares++;
         $display("FAIL busywr_no_restart: got %b expected 00", {busy, ps2_clk_oe});
      end
   endtask

   task automatic test_clear_collision;
      int n; logic dat; logic [9:0] bits; bit ok; bit cleared_ok; logic [31:0] v;
      reg_write(1'b0, 32'h0000_00ED);
      measure_inhibit(n, dat);
      cleared_ok = 1'b0;
      fork
         dev_frame(11, 1'b1, bits, ok);
         begin
            for (int i = 0; i < 400; i++) begin
               @(negedge clk);
               if (busy) begin
                  a = 1'b1; d = 32'h1; we = 1'b1;
               end else begin
                  we = 1'b0;
                  cleared_ok = 1'b1;
                  break;
               end
            end
            we = 1'b0;
         end
      join
      vectors++;
      if (!cleared_ok) begin miscompares++; $display("FAIL collide_timeout: got busy expected idle"); end
      read_status(v);
      vectors++;
      if (v !== 32'h6) begin miscompares++; $display("FAIL collide_set_wins: got %h expected 6", v); end
   endtask

   task automatic test_reset_mid;
      int n; logic dat; logic [9:0] bits; bit ok; logic [31:0] v;
      reg_write(1'b0, 32'h0000_00F0);
      measure_inhibit(n, dat);
      dev_frame(5, 1'b0, bits, ok);
      vectors++;
      if ({busy, ps2_data_oe} !== 2'b10) begin
         miscompares++;
         $display("FAIL rstmid_bit4: got %b expected 10", {busy, ps2_data_oe});
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      read_status(v);
      vectors++;
      if ({ps2_clk_oe, ps2_data_oe, busy} !== 3'b000 || v !== 32'h0) begin
         miscompares++;
         $display("FAIL rstmid_cleared: got oe/busy %b status %h expected 000 and 0",
                  {ps2_clk_oe, ps2_data_oe, busy}, v);
      end
      rst = 1'b0;
      repeat (3) @(negedge clk);
      reg_write(1'b0, 32'h0000_00FF);
      measure_inhibit(n, dat);
      dev_frame(11, 1'b1, bits, ok);
      vectors++;
      if (bits !== 10'b11_1111_1111) begin
         miscompares++;
         $display("FAIL ff_bits: got %b expected 1111111111", bits);
      end
      wait_idle(ok);
      read_status(v);
      vectors++;
      if (!ok || v !== 32'h6) begin miscompares++; $display("FAIL ff_status: got %h expected 6", v); end
   endtask

   task automatic test_timeout;
      int n; int m; logic dat; logic [31:0] v;
      reg_write(1'b0, 32'h0000_003C);
      measure_inhibit(n, dat);
      m = 0;
      while (ps2_data_oe && m < 400) begin
         m++;
         @(negedge clk);
      end
      vectors++;
      if (m !== TMO) begin miscompares++; $display("FAIL tmo_len: got %0d expected %0d", m, TMO); end
      read_status(v);
      vectors++;
      if ({ps2_clk_oe, ps2_data_oe} !== 2'b00 || v !== 32'hA) begin
         miscompares++;
         $display("FAIL tmo_status: got oe %b status %h expected 00 and a", {ps2_clk_oe, ps2_data_oe}, v);
      end
      reg_write(1'b1, 32'h2);
      #1;
      vectors++;
      if (irq !== 1'b1 || spo !== 32'h2) begin
         miscompares++;
         $display("FAIL tmo_irq_on: got irq %b ctrl %h expected 1 and 2", irq, spo);
      end
      reg_write(1'b1, 32'h3);
      read_status(v);
      vectors++;
      if (irq !== 1'b0 || v !== 32'h0) begin
         miscompares++;
         $display("FAIL tmo_irq_clear: got irq %b status %h expected 0 and 0", irq, v);
      end
   endtask

   initial begin
      test_reset;
      test_send_ack;
      test_send_noack;
      test_busy_write;
      test_clear_collision;
      test_reset_mid;
      test_timeout;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
